seg_scan_receiver: RTL and testbench
====================================

SEG_SCAN_RECEIVER -- requirements
Module: seg_scan_receiver

Interface
REQ-001 Parameter SETTLE, default 4: consecutive stable cycles of an unchanged (enable, segment) pair required before that digit is captured; legal range 1..255.
REQ-002 Parameter TIMEOUT, default 50000: cycles without a completed frame before stale asserts; 16-bit.
REQ-003 Parameter SEG_ACTIVE_LOW, default 0: 1 means segment is active-low and is inverted before decoding.
REQ-004 Parameter EN_ACTIVE_LOW, default 0: 1 means enable is active-low and is inverted before decoding.
REQ-005 clk  input  1  single system clock; all logic on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 enable  input  4  digit-select lines from the scanned display; bit n selects digit n.
REQ-008 segment  input  7  segment lines, order abcdefg, a = bit 6.
REQ-009 seg3, seg2, seg1, seg0  output  4 each  reconstructed hex value of digits 3..0, registered.
REQ-010 blank  output  4  bit n = 1 when digit n was captured with all segments off.
REQ-011 frame_valid  output  1  one-cycle pulse; seg3..seg0 and blank were updated this cycle.
REQ-012 pattern_err  output  1  one-cycle pulse; a settled pattern matched no table entry.
REQ-013 enable_err  output  1  one-cycle pulse; enable became non-zero and not one-hot.
REQ-014 stale  output  1  level; no frame completed within TIMEOUT cycles.

Function
REQ-015 Inputs are normalised by the polarity parameters; all further requirements refer to active-high values.
REQ-016 Decode table (abcdefg to value): 1111110=0, 0110000=1, 1101101=2, 1111001=3, 0110011=4, 1011011=5, 1011111=6, 1110000=7, 1111111=8, 1111011=9, 1110111=A, 0011111=b, 1001110=C, 0111101=d, 1001111=E, 1000111=F.
REQ-017 Pattern 0000000 is legal blank: value 0, blank bit 1. Any other unlisted pattern is illegal.
REQ-018 FSM states: IDLE, SETTLE, HOLD.
- IDLE: enable is zero or not one-hot.
- SETTLE: counting stable cycles.
- HOLD: current digit already handled.
REQ-019 IDLE to SETTLE: enable is one-hot. The settle counter loads 1 and the (enable, segment) pair is latched.
REQ-020 SETTLE: a cycle with the pair equal to the latched pair increments the counter. A changed but still one-hot pair re-latches and reloads 1. Zero or non-one-hot enable goes to IDLE.
REQ-021 When the counter reaches SETTLE:
- legal pattern: write the decoded value and blank flag into the shadow register of the selected digit and set that capture-mask bit.
- illegal pattern: pulse pattern_err and leave shadow and mask unchanged.
- either way, go to HOLD on the next cycle.
REQ-022 With SETTLE=1, capture happens on the first cycle the pair is seen.
REQ-023 HOLD: no further capture or error while the pair is unchanged. A changed one-hot pair goes to SETTLE with reload. Zero or non-one-hot enable goes to IDLE.
REQ-024 enable_err pulses on the first cycle enable is non-zero and not one-hot after any other enable value, then stays low until that condition ends and recurs.
REQ-025 Recapturing a digit whose mask bit is already set overwrites its shadow value without error.
REQ-026 When the mask becomes 1111, on the next cycle:
- seg3..seg0 and blank load from the shadow registers simultaneously;
- frame_valid pulses;
- the mask clears to 0000.
REQ-027 A capture in the commit cycle is written to the shadow register after the commit and sets the mask bit for the next frame.
REQ-028 Outputs seg3..seg0 and blank change only on frame_valid cycles.
REQ-029 Stale counter: clears on frame_valid, otherwise increments and saturates at TIMEOUT. stale = (counter == TIMEOUT) and is forced 0 on a frame_valid cycle.

Reset
REQ-030 While reset = 0 at a clock edge:
- FSM goes to IDLE; mask, shadows, settle counter and stale counter clear;
- seg3..seg0 = 0, blank = 1111;
- frame_valid, pattern_err, enable_err = 0;
- stale = 0.
REQ-031 Reset mid-frame discards partial captures; no frame_valid follows for that frame.

Verification
REQ-032 Scan digits 3,2,1,0 showing 2,0,2,4 for 6 cycles each, with 1 blank-enable cycle between digits (SETTLE=4) -> one frame_valid; seg3..seg0 = 2,0,2,4; blank = 0000; no error pulses.
REQ-033 Digit 1 is held for only 3 cycles -> no capture of digit 1 and no frame_valid until digit 1 is later held for at least 4 cycles.
REQ-034 Pattern 1010101 is held 6 cycles on digit 0 -> exactly one pattern_err pulse; mask bit 0 stays clear.
REQ-035 enable = 0101 for 3 cycles -> one enable_err pulse and FSM in IDLE; a following legal scan completes a normal frame.
REQ-036 TIMEOUT = 20 with no scanning after reset -> stale rises on cycle 20 after reset release; a later full frame clears it on the frame_valid cycle.
REQ-037 Reset is asserted after 3 of 4 digits are captured -> outputs return to reset values; the 4th digit alone produces no frame_valid.

Source files
------------

// File: rtl/seg_scan_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_receiver
//  Purpose  : Reconstructs the four hex digits shown on a multiplexed
//             (scanned) 7-segment display. Each digit is accepted only after
//             its (enable, segment) pair has been stable for SETTLE cycles.
//             A frame of all four digits is published at once.
//  Ports    : clk          - system clock, rising edge
//             reset        - synchronous reset, active low
//             enable[3:0]  - digit selects, bit n selects digit n
//             segment[6:0] - segment lines abcdefg, a = bit 6
//             seg3..seg0   - registered hex value of digits 3..0
//             blank[3:0]   - bit n set when digit n was captured all-off
//             frame_valid  - pulse, seg3..seg0/blank updated this cycle
//             pattern_err  - pulse, a settled pattern is not a hex glyph
//             enable_err   - pulse, enable went multi-hot
//             stale        - level, no frame completed within TIMEOUT cycles
//  Revision : 1.0 - initial release
// ============================================================================
module seg_scan_receiver #(
    parameter int          SETTLE         = 4,
    parameter logic [15:0] TIMEOUT        = 16'd50000,
    parameter bit          SEG_ACTIVE_LOW = 1'b0,
    parameter bit          EN_ACTIVE_LOW  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] enable,
    input  logic [6:0] segment,
    output logic [3:0] seg3,
    output logic [3:0] seg2,
    output logic [3:0] seg1,
    output logic [3:0] seg0,
    output logic [3:0] blank,
    output logic       frame_valid,
    output logic       pattern_err,
    output logic       enable_err,
    output logic       stale
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_hold   = 2'd2;
    localparam logic [7:0] c_settle    = 8'(SETTLE);

    logic [1:0]  r_state;
    logic [7:0]  r_cnt;
    logic [3:0]  r_lat_en;
    logic [6:0]  r_lat_seg;
    logic [3:0]  r_mask;
    logic [3:0]  r_shadow [4];
    logic [3:0]  r_shadow_blank;
    logic [3:0]  r_seg3, r_seg2, r_seg1, r_seg0;
    logic [3:0]  r_blank;
    logic        r_frame_valid;
    logic        r_pattern_err;
    logic        r_enable_err;
    logic        r_bad_en_d;
    logic [15:0] r_stale_cnt;

    logic [3:0]  w_en;
    logic [6:0]  w_seg;
    logic        w_onehot;
    logic        w_bad_en;
    logic        w_same;
    logic [1:0]  w_state_nxt;
    logic [7:0]  w_cnt_nxt;
    logic        w_counting;
    logic        w_done;
    logic [3:0]  w_dec_val;
    logic        w_dec_legal;
    logic        w_dec_blank;
    logic [1:0]  w_idx;
    logic        w_capture;
    logic        w_commit;

    // Polarity normalisation: everything downstream is active high.
    assign w_en  = EN_ACTIVE_LOW  ? ~enable  : enable;
    assign w_seg = SEG_ACTIVE_LOW ? ~segment : segment;

    assign w_onehot = (w_en != 4'd0) && ((w_en & (w_en - 4'd1)) == 4'd0);
    assign w_bad_en = (w_en != 4'd0) && !w_onehot;
    assign w_same   = (w_en == r_lat_en) && (w_seg == r_lat_seg);

    // Next state. w_cnt_nxt is the stable-cycle count including the current
    // cycle, so SETTLE=1 captures on the first cycle a pair is seen.
    always_comb begin
        w_state_nxt = c_st_idle;
        w_cnt_nxt   = 8'd0;
        w_counting  = 1'b0;
        if (w_onehot) begin
            if ((r_state == c_st_hold) && w_same) begin
                w_state_nxt = c_st_hold;
                w_cnt_nxt   = r_cnt;
            end else begin
                w_counting  = 1'b1;
                w_cnt_nxt   = ((r_state == c_st_settle) && w_same) ? r_cnt + 8'd1 : 8'd1;
                w_state_nxt = (w_cnt_nxt == c_settle) ? c_st_hold : c_st_settle;
            end
        end
    end

    assign w_done = w_counting && (w_cnt_nxt == c_settle);

    // Segment decoder (abcdefg -> hex). All-off is a legal blank digit.
    always_comb begin
        w_dec_val   = 4'h0;
        w_dec_legal = 1'b1;
        w_dec_blank = 1'b0;
        case (w_seg)
            7'b1111110: w_dec_val = 4'h0;
            7'b0110000: w_dec_val = 4'h1;
            7'b1101101: w_dec_val = 4'h2;
            7'b1111001: w_dec_val = 4'h3;
            7'b0110011: w_dec_val = 4'h4;
            7'b1011011: w_dec_val = 4'h5;
            7'b1011111: w_dec_val = 4'h6;
            7'b1110000: w_dec_val = 4'h7;
            7'b1111111: w_dec_val = 4'h8;
            7'b1111011: w_dec_val = 4'h9;
            7'b1110111: w_dec_val = 4'hA;
            7'b0011111: w_dec_val = 4'hB;
            7'b1001110: w_dec_val = 4'hC;
            7'b0111101: w_dec_val = 4'hD;
            7'b1001111: w_dec_val = 4'hE;
            7'b1000111: w_dec_val = 4'hF;
            7'b0000000: w_dec_blank = 1'b1;
            default:    w_dec_legal = 1'b0;
        endcase
    end

    always_comb begin
        w_idx = 2'd0;
        case (w_en)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
    end

    assign w_capture = w_done && w_dec_legal;
    assign w_commit  = (r_mask == 4'b1111);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state        <= c_st_idle;
            r_cnt          <= 8'd0;
            r_lat_en       <= 4'd0;
            r_lat_seg      <= 7'd0;
            r_mask         <= 4'd0;
            for (int i = 0; i < 4; i++) r_shadow[i] <= 4'd0;
            r_shadow_blank <= 4'd0;
            r_seg3         <= 4'd0;
            r_seg2         <= 4'd0;
            r_seg1         <= 4'd0;
            r_seg0         <= 4'd0;
            r_blank        <= 4'b1111;
            r_frame_valid  <= 1'b0;
            r_pattern_err  <= 1'b0;
            r_enable_err   <= 1'b0;
            r_bad_en_d     <= 1'b0;
            r_stale_cnt    <= 16'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_counting) begin
                r_lat_en  <= w_en;
                r_lat_seg <= w_seg;
            end

            // A capture landing in the commit cycle belongs to the next frame:
            // the mask clears and the new bit is OR-ed in afterwards.
            r_mask <= (w_commit ? 4'd0 : r_mask) | (w_capture ? w_en : 4'd0);
            if (w_capture) begin
                r_shadow[w_idx]       <= w_dec_val;
                r_shadow_blank[w_idx] <= w_dec_blank;
            end

            r_frame_valid <= w_commit;
            if (w_commit) begin
                r_seg3  <= r_shadow[3];
                r_seg2  <= r_shadow[2];
                r_seg1  <= r_shadow[1];
                r_seg0  <= r_shadow[0];
                r_blank <= r_shadow_blank;
            end

            r_pattern_err <= w_done && !w_dec_legal;
            r_enable_err  <= w_bad_en && !r_bad_en_d;
            r_bad_en_d    <= w_bad_en;

            if (w_commit)
                r_stale_cnt <= 16'd0;
            else if (r_stale_cnt != TIMEOUT)
                r_stale_cnt <= r_stale_cnt + 16'd1;
        end
    end

    assign seg3        = r_seg3;
    assign seg2        = r_seg2;
    assign seg1        = r_seg1;
    assign seg0        = r_seg0;
    assign blank       = r_blank;
    assign frame_valid = r_frame_valid;
    assign pattern_err = r_pattern_err;
    assign enable_err  = r_enable_err;
    assign stale       = (r_stale_cnt == TIMEOUT) && !r_frame_valid;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_receiver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_receiver
//  Purpose  : Self-checking bench for seg_scan_receiver. Two instances: one
//             with SETTLE=4/TIMEOUT=20/active-high lines, one with SETTLE=1
//             and both polarities inverted, fed the inverted stimulus.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_receiver;

    localparam logic [6:0] c_p0 = 7'b1111110, c_p1 = 7'b0110000, c_p2 = 7'b1101101,
                           c_p3 = 7'b1111001, c_p4 = 7'b0110011, c_p5 = 7'b1011011,
                           c_p6 = 7'b1011111, c_p7 = 7'b1110000, c_p8 = 7'b1111111,
                           c_p9 = 7'b1111011, c_pa = 7'b1110111, c_pb = 7'b0011111,
                           c_pc = 7'b1001110, c_pd = 7'b0111101, c_pe = 7'b1001111,
                           c_pf = 7'b1000111, c_pz = 7'b0000000, c_bad = 7'b1010101;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] enable;
    logic [6:0] segment;

    logic [3:0] seg3, seg2, seg1, seg0, blank;
    logic       frame_valid, pattern_err, enable_err, stale;
    logic [3:0] i_seg3, i_seg2, i_seg1, i_seg0, i_blank;
    logic       i_fv, i_perr, i_eerr, i_stale;

    always #5 clk = ~clk;

    seg_scan_receiver #(.SETTLE(4), .TIMEOUT(16'd20), .SEG_ACTIVE_LOW(1'b0), .EN_ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .segment(segment),
        .seg3(seg3), .seg2(seg2), .seg1(seg1), .seg0(seg0), .blank(blank),
        .frame_valid(frame_valid), .pattern_err(pattern_err),
        .enable_err(enable_err), .stale(stale));

    seg_scan_receiver #(.SETTLE(1), .TIMEOUT(16'd20), .SEG_ACTIVE_LOW(1'b1), .EN_ACTIVE_LOW(1'b1)) dut_inv (
        .clk(clk), .reset(reset), .enable(~enable), .segment(~segment),
        .seg3(i_seg3), .seg2(i_seg2), .seg1(i_seg1), .seg0(i_seg0), .blank(i_blank),
        .frame_valid(i_fv), .pattern_err(i_perr),
        .enable_err(i_eerr), .stale(i_stale));

    // Event monitor, sampled on the falling edge.
    int          fv_cnt = 0, perr_cnt = 0, eerr_cnt = 0, ifv_cnt = 0, iperr_cnt = 0, hold_viol = 0;
    logic [15:0] fv_vals, ifv_vals;
    logic [3:0]  fv_blank, ifv_blank;
    logic        fv_stale;
    logic [19:0] prev_out;
    logic        prev_rst;

    always @(negedge clk) begin
        if (frame_valid) begin
            fv_cnt++;
            fv_vals  = {seg3, seg2, seg1, seg0};
            fv_blank = blank;
            fv_stale = stale;
        end
        if (pattern_err) perr_cnt++;
        if (enable_err)  eerr_cnt++;
        if (i_fv) begin
            ifv_cnt++;
            ifv_vals  = {i_seg3, i_seg2, i_seg1, i_seg0};
            ifv_blank = i_blank;
        end
        if (i_perr) iperr_cnt++;
        if ((reset === 1'b1) && (prev_rst === 1'b1) && !frame_valid &&
            ({seg3, seg2, seg1, seg0, blank} !== prev_out))
            hold_viol++;
        prev_out = {seg3, seg2, seg1, seg0, blank};
        prev_rst = reset;
    end

    int n_vec = 0, n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Present a pair for n sampled cycles; returns 1 time unit after the last edge.
    task automatic drive(input logic [3:0] en, input logic [6:0] sg, input int n);
        enable  = en;
        segment = sg;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] sg, input int n);
        drive(4'(4'b0001 << d), sg, n);
        drive(4'b0000, c_pz, 1);
    endtask

    task automatic scan_frame(input logic [27:0] pats);
        for (int d = 3; d >= 0; d--) show(d, pats[d*7 +: 7], 6);
        drive(4'b0000, c_pz, 3);
    endtask

    typedef struct {
        logic [27:0] pats;
        logic [15:0] vals;
        logic [3:0]  blank;
    } vec_t;

    vec_t tbl [6];
    int   b_fv, b_pe, b_ee, b_ifv, k;

    initial begin
        tbl[0] = '{pats: {c_p2, c_p0, c_p2, c_p4}, vals: 16'h2024, blank: 4'b0000};
        tbl[1] = '{pats: {c_p1, c_p3, c_p5, c_p7}, vals: 16'h1357, blank: 4'b0000};
        tbl[2] = '{pats: {c_p6, c_p8, c_p9, c_pa}, vals: 16'h689A, blank: 4'b0000};
        tbl[3] = '{pats: {c_pb, c_pc, c_pd, c_pe}, vals: 16'hBCDE, blank: 4'b0000};
        tbl[4] = '{pats: {c_pf, c_pz, c_p4, c_pz}, vals: 16'hF040, blank: 4'b0101};
        tbl[5] = '{pats: {c_pz, c_pz, c_pz, c_pz}, vals: 16'h0000, blank: 4'b1111};

        reset = 1'b0; enable = 4'b0000; segment = c_pz;
        repeat (3) @(posedge clk);
        #1;
        check("reset_segs",  {16'd0, seg3, seg2, seg1, seg0}, 32'h0);
        check("reset_blank", {28'd0, blank}, 32'hF);
        check("reset_flags", {28'd0, frame_valid, pattern_err, enable_err, stale}, 32'h0);
        check("reset_inv_blank", {28'd0, i_blank}, 32'hF);

        // Stale rises on the 20th cycle after reset release with no scanning.
        reset = 1'b1;
        k = 41;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk);
            #1;
            if (stale) begin k = c; break; end
        end
        check("stale_rise_cycle", k, 20);

        // Table-driven full frames.
        for (int v = 0; v < 6; v++) begin
            b_fv = fv_cnt; b_pe = perr_cnt; b_ee = eerr_cnt; b_ifv = ifv_cnt;
            scan_frame(tbl[v].pats);
            check($sformatf("v%0d_fv_count", v), fv_cnt - b_fv, 1);
            check($sformatf("v%0d_vals", v), {16'd0, fv_vals}, {16'd0, tbl[v].vals});
            check($sformatf("v%0d_blank", v), {28'd0, fv_blank}, {28'd0, tbl[v].blank});
            check($sformatf("v%0d_errs", v), (perr_cnt - b_pe) + (eerr_cnt - b_ee), 0);
            check($sformatf("v%0d_inv_fv_count", v), ifv_cnt - b_ifv, 1);
            check($sformatf("v%0d_inv_vals", v), {12'd0, ifv_vals, ifv_blank},
                  {12'd0, tbl[v].vals, tbl[v].blank});
            if (v == 0) begin
                check("stale_at_frame_valid", {31'd0, fv_stale}, 0);
                check("stale_after_frame", {31'd0, stale}, 0);
            end
        end

        // Digit 1 held only 3 cycles: no frame until it is held 4.
        b_fv = fv_cnt;
        show(3, c_p2, 6); show(2, c_p0, 6); show(1, c_p2, 3); show(0, c_p4, 6);
        drive(4'b0000, c_pz, 3);
        check("short_hold_no_frame", fv_cnt - b_fv, 0);
        show(1, c_p1, 4);
        drive(4'b0000, c_pz, 3);
        check("short_hold_then_frame", fv_cnt - b_fv, 1);
        check("short_hold_vals", {16'd0, fv_vals}, 32'h2014);

        // Illegal pattern held on digit 0: one error, mask bit 0 stays clear.
        b_fv = fv_cnt; b_pe = perr_cnt;
        show(0, c_bad, 6);
        drive(4'b0000, c_pz, 2);
        check("illegal_perr_count", perr_cnt - b_pe, 1);
        show(3, c_p8, 6); show(2, c_p8, 6); show(1, c_p8, 6);
        drive(4'b0000, c_pz, 3);
        check("illegal_no_frame", fv_cnt - b_fv, 0);
        show(0, c_p8, 6);
        drive(4'b0000, c_pz, 3);
        check("illegal_then_frame", fv_cnt - b_fv, 1);
        check("illegal_then_vals", {16'd0, fv_vals}, 32'h8888);

        // Multi-hot enable: one pulse per episode, then normal frame.
        b_fv = fv_cnt; b_ee = eerr_cnt;
        drive(4'b0101, c_p8, 3);
        drive(4'b0000, c_pz, 2);
        check("enable_err_pulse", eerr_cnt - b_ee, 1);
        scan_frame({c_p1, c_p3, c_p5, c_p7});
        check("enable_err_then_frame", fv_cnt - b_fv, 1);
        check("enable_err_then_vals", {16'd0, fv_vals}, 32'h1357);
        b_ee = eerr_cnt;
        drive(4'b0101, c_p8, 2); drive(4'b1110, c_p8, 2);
        drive(4'b0000, c_pz, 1); drive(4'b0011, c_p8, 1);
        drive(4'b0000, c_pz, 2);
        check("enable_err_episodes", eerr_cnt - b_ee, 2);

        // Recapture of a digit overwrites its shadow value.
        b_fv = fv_cnt;
        show(3, c_p1, 6); show(3, c_p7, 6);
        show(2, c_p0, 6); show(1, c_p0, 6); show(0, c_p0, 6);
        drive(4'b0000, c_pz, 3);
        check("recapture_fv", fv_cnt - b_fv, 1);
        check("recapture_vals", {16'd0, fv_vals}, 32'h7000);

        // Reset after three of four digits: partial frame discarded.
        b_fv = fv_cnt;
        show(3, c_p1, 6); show(2, c_p2, 6); show(1, c_p3, 6);
        reset = 1'b0;
        drive(4'b0000, c_pz, 2);
        check("midreset_segs",  {16'd0, seg3, seg2, seg1, seg0}, 32'h0);
        check("midreset_blank", {28'd0, blank}, 32'hF);
        reset = 1'b1;
        show(0, c_p4, 6);
        drive(4'b0000, c_pz, 4);
        check("midreset_no_frame", fv_cnt - b_fv, 0);
        check("midreset_outputs_kept", {12'd0, seg3, seg2, seg1, seg0, blank}, 32'h0000F);

        check("outputs_stable_off_frame", hold_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
